// File: rtl/demux_1_4.sv
// Registered 1-to-4 demultiplexer. Each output lane owns its own data/valid flops.
// The lane's data is cleared on any routed sample aimed at another lane and held when EN is low.

module demux_1_4_lane #(
   parameter int         BITS_NUM = 2,
   parameter logic [1:0] LANE_ID  = 2'd0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [BITS_NUM-1:0] x_i,
   input  logic [1:0]          sel_i,
   output logic [BITS_NUM-1:0] y_o,
   output logic                vld_o
);

   logic [BITS_NUM-1:0] y_q, y_d;
   logic                vld_q, vld_d;
   logic                hit;

   assign hit = (sel_i == LANE_ID);

   always_comb begin
      y_d   = y_q;
      vld_d = 1'b0;
      if (en_i) begin
         // A sample aimed elsewhere still clears this lane.
         y_d   = hit ? x_i : '0;
         vld_d = hit;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   assign y_o   = y_q;
   assign vld_o = vld_q;

endmodule

module demux_1_4 #(
   parameter int BITS_NUM = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic [BITS_NUM-1:0] X,
   input  logic [1:0]          SEL,
   output logic [BITS_NUM-1:0] Y0,
   output logic [BITS_NUM-1:0] Y1,
   output logic [BITS_NUM-1:0] Y2,
   output logic [BITS_NUM-1:0] Y3,
   output logic [3:0]          VLD
);

   localparam int NUM_LANES = 4;

   logic [NUM_LANES-1:0][BITS_NUM-1:0] y_w;
   logic [NUM_LANES-1:0]               vld_w;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      demux_1_4_lane #(
         .BITS_NUM (BITS_NUM),
         .LANE_ID  (2'(i))
      ) u_lane (
         .clk_i (CLK),
         .rst_i (RST),
         .en_i  (EN),
         .x_i   (X),
         .sel_i (SEL),
         .y_o   (y_w[i]),
         .vld_o (vld_w[i])
      );
   end

   assign Y0  = y_w[0];
   assign Y1  = y_w[1];
   assign Y2  = y_w[2];
   assign Y3  = y_w[3];
   assign VLD = vld_w;

endmodule

// File: tb/tb_demux_1_4.sv
// Directed table-driven bench for demux_1_4: a 2-bit instance runs the vector table,
// an 8-bit instance checks bit-for-bit routing at a wider width.

module tb_demux_1_4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en;
   logic [1:0] x, sel;
   logic [1:0] y0, y1, y2, y3;
   logic [3:0] vld;

   logic       w_rst, w_en;
   logic [7:0] w_x;
   logic [1:0] w_sel;
   logic [7:0] w_y0, w_y1, w_y2, w_y3;
   logic [3:0] w_vld;

   demux_1_4 #(.BITS_NUM(2)) dut (
      .CLK(clk), .RST(rst), .EN(en), .X(x), .SEL(sel),
      .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3), .VLD(vld)
   );

   demux_1_4 #(.BITS_NUM(8)) dut_w (
      .CLK(clk), .RST(w_rst), .EN(w_en), .X(w_x), .SEL(w_sel),
      .Y0(w_y0), .Y1(w_y1), .Y2(w_y2), .Y3(w_y3), .VLD(w_vld)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] x;
      logic [1:0] sel;
      logic [1:0] y0, y1, y2, y3;
      logic [3:0] vld;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic r, logic e, logic [1:0] xx, logic [1:0] s,
                               logic [1:0] a, logic [1:0] b, logic [1:0] c,
                               logic [1:0] d, logic [3:0] v);
      vec_t t;
      t.rst = r; t.en = e; t.x = xx; t.sel = s;
      t.y0 = a; t.y1 = b; t.y2 = c; t.y3 = d; t.vld = v;
      return t;
   endfunction

   task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_all(string nm, logic [1:0] a, logic [1:0] b, logic [1:0] c,
                          logic [1:0] d, logic [3:0] v);
      chk({nm, " Y0"}, 8'(y0), 8'(a));
      chk({nm, " Y1"}, 8'(y1), 8'(b));
      chk({nm, " Y2"}, 8'(y2), 8'(c));
      chk({nm, " Y3"}, 8'(y3), 8'(d));
      chk({nm, " VLD"}, 8'(vld), 8'(v));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; x = '0; sel = '0;
      w_rst = 1'b1; w_en = 1'b0; w_x = '0; w_sel = '0;

      //        rst  en   x     sel    Y0     Y1     Y2     Y3     VLD
      tbl.push_back(mk(1, 1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000)); // reset
      tbl.push_back(mk(1, 1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 4'b0001)); // sweep
      tbl.push_back(mk(0, 1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 4'b0010));
      tbl.push_back(mk(0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 4'b0100));
      tbl.push_back(mk(0, 1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1000));
      tbl.push_back(mk(0, 1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 4'b0001)); // wrap 3->0
      tbl.push_back(mk(0, 1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 4'b1000)); // hold setup
      tbl.push_back(mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0000));
      tbl.push_back(mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0000));
      tbl.push_back(mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0000));
      tbl.push_back(mk(0, 1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0010)); // zero data
      tbl.push_back(mk(0, 1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 4'b0001)); // mid reset
      tbl.push_back(mk(0, 1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 4'b0010));
      tbl.push_back(mk(1, 1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1000));
      tbl.push_back(mk(1, 0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000)); // RST over idle
      tbl.push_back(mk(0, 0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000));
      tbl.push_back(mk(0, 1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 4'b0100));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; en = tbl[i].en; x = tbl[i].x; sel = tbl[i].sel;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].y0, tbl[i].y1, tbl[i].y2,
                 tbl[i].y3, tbl[i].vld);
      end

      // Inputs changing mid-cycle must not reach the outputs before the next edge.
      @(negedge clk);
      rst = 1'b0; en = 1'b1; x = 2'd1; sel = 2'd0;
      #1;
      chk_all("nocomb", 2'd0, 2'd0, 2'd3, 2'd0, 4'b0100);
      @(posedge clk);
      #1;
      chk_all("nocomb_next", 2'd1, 2'd0, 2'd0, 2'd0, 4'b0001);

      // Wide instance: bit-for-bit routing at BITS_NUM=8.
      @(negedge clk);
      en = 1'b0;
      w_rst = 1'b0; w_en = 1'b1; w_x = 8'hA5; w_sel = 2'd2;
      @(posedge clk);
      #1;
      chk("w8 Y0", w_y0, 8'h00);
      chk("w8 Y1", w_y1, 8'h00);
      chk("w8 Y2", w_y2, 8'hA5);
      chk("w8 Y3", w_y3, 8'h00);
      chk("w8 VLD", 8'(w_vld), 8'h04);
      @(negedge clk);
      w_x = 8'h3C; w_sel = 2'd0;
      @(posedge clk);
      #1;
      chk("w8b Y0", w_y0, 8'h3C);
      chk("w8b Y2", w_y2, 8'h00);
      chk("w8b VLD", 8'(w_vld), 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
